// File: rtl/id_register_file_pkg.sv
// Shared definitions for the ID-stage register file and its dump sequencer.
package id_register_file_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  // Derived from the index width so the array is always fully addressable.
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDump = 2'd1,
    StDone = 2'd2
  } dump_state_e;

  // Read with write-back bypass: r0 reads 0, an in-flight write to the same index wins,
  // otherwise the stored value is returned.
  function automatic reg_data_t bypass_sel(input reg_addr_t rd_addr,
                                           input logic      wr_en,
                                           input reg_addr_t wr_addr,
                                           input reg_data_t wr_data,
                                           input reg_data_t stored);
    reg_data_t result;
    if (rd_addr == '0) begin
      result = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      result = wr_data;
    end else begin
      result = stored;
    end
    return result;
  endfunction

endpackage

// File: rtl/id_register_file_if.sv
// Bundle of the WB write port, the two ID read ports and the debug dump stream.
interface id_register_file_if;
  import id_register_file_pkg::*;

  logic      wb_reg_write;
  reg_addr_t wb_write_addr;
  reg_data_t wb_write_data;

  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  reg_data_t rd_data_a;
  reg_data_t rd_data_b;

  logic      dump_start;
  logic      dump_ready;
  logic      dump_valid;
  reg_addr_t dump_addr;
  reg_data_t dump_data;
  logic      dump_busy;
  logic      dump_done;

  // Writer/readers side (WB stage, ID stage, debug unit).
  modport master (
    output wb_reg_write, wb_write_addr, wb_write_data,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    output dump_start, dump_ready,
    input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  // Register file side.
  modport slave (
    input  wb_reg_write, wb_write_addr, wb_write_data,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    input  dump_start, dump_ready,
    output dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/id_register_file_regfile_dump_seq.sv
// Dump sequencer: streams every register out over a valid/ready handshake.
// Each word is captured when loaded, so later writes never disturb a presented word.
module regfile_dump_seq
  import id_register_file_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      dump_start,
  input  logic      dump_ready,
  output reg_addr_t load_addr,
  input  reg_data_t load_data,
  output logic      dump_valid,
  output reg_addr_t dump_addr,
  output reg_data_t dump_data,
  output logic      dump_busy,
  output logic      dump_done
);

  dump_state_e state_q, state_d;
  logic        valid_q, valid_d;
  reg_addr_t   addr_q, addr_d;
  reg_data_t   data_q, data_d;
  logic        last_word;

  assign last_word = (addr_q == reg_addr_t'(NUM_REGS - 1));

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state, word loading and status outputs.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    load_addr = (state_q == StIdle) ? '0 : addr_q + reg_addr_t'(1);

    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StDump;
          valid_d = 1'b1;
          addr_d  = '0;
          data_d  = load_data;
        end
      end
      StDump: begin
        if (valid_q && dump_ready) begin
          if (last_word) begin
            state_d = StDone;
            valid_d = 1'b0;
          end else begin
            addr_d = load_addr;
            data_d = load_data;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase

    dump_valid = valid_q;
    dump_addr  = addr_q;
    dump_data  = data_q;
    dump_busy  = (state_q == StDump) || (state_q == StDone);
    dump_done  = (state_q == StDone);
  end

endmodule

// File: rtl/id_register_file.sv
// ID-stage register file: one WB write port, two bypassed zero-latency read ports
// and a dump sequencer for the debug unit.
module id_register_file
  import id_register_file_pkg::*;
(
  input logic               clk,
  input logic               reset,
  id_register_file_if.slave bus
);

  reg_data_t regs_q [NUM_REGS];
  reg_addr_t load_addr;
  reg_data_t load_data;

  // Storage array; index 0 is never written so it stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wb_reg_write && (bus.wb_write_addr != '0)) begin
      regs_q[bus.wb_write_addr] <= bus.wb_write_data;
    end
  end

  // Combinational read ports, plus the sequencer's load port, all with bypass.
  always_comb begin
    bus.rd_data_a = bypass_sel(bus.rd_addr_a, bus.wb_reg_write, bus.wb_write_addr,
                               bus.wb_write_data, regs_q[bus.rd_addr_a]);
    bus.rd_data_b = bypass_sel(bus.rd_addr_b, bus.wb_reg_write, bus.wb_write_addr,
                               bus.wb_write_data, regs_q[bus.rd_addr_b]);
    load_data     = bypass_sel(load_addr, bus.wb_reg_write, bus.wb_write_addr,
                               bus.wb_write_data, regs_q[load_addr]);
  end

  regfile_dump_seq u_dump_seq (
    .clk        (clk),
    .reset      (reset),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .dump_valid (bus.dump_valid),
    .dump_addr  (bus.dump_addr),
    .dump_data  (bus.dump_data),
    .dump_busy  (bus.dump_busy),
    .dump_done  (bus.dump_done)
  );

endmodule

// File: tb/tb_id_register_file.sv
// Self-checking bench for id_register_file with a behavioural register model.
module tb_id_register_file;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_register_file_if bus ();

  id_register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mregs [32];
  int n_pass = 0;
  int n_total = 0;

  // Architectural read rule applied to the current stimulus.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.wb_reg_write && (bus.wb_write_addr == a)) return bus.wb_write_data;
    return mregs[a];
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else if (bus.wb_reg_write && (bus.wb_write_addr != 5'd0)) begin
      mregs[bus.wb_write_addr] = bus.wb_write_data;
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_addr = 5'd0;
    bus.wb_write_data = 32'h0;
    bus.rd_addr_a     = 5'd0;
    bus.rd_addr_b     = 5'd0;
    bus.dump_start    = 1'b0;
    bus.dump_ready    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd9;
    bus.wb_write_data = $urandom;
    tick();
    reset = 1'b0;
    bus.wb_reg_write = 1'b0;
    #1;
    n_total++;
    if ({bus.dump_valid, bus.dump_busy, bus.dump_done, bus.dump_addr, bus.dump_data} !== '0)
      $display("FAIL reset_dump_outputs: got v%b b%b d%b a%0d %h, want all 0", bus.dump_valid,
               bus.dump_busy, bus.dump_done, bus.dump_addr, bus.dump_data);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      #1;
      n_total++;
      if ((bus.rd_data_a !== 32'h0) || (bus.rd_data_b !== 32'h0))
        $display("FAIL reset_regs r%0d: got a=%h b=%h, want 0", i, bus.rd_data_a, bus.rd_data_b);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_write_read();
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd5;
    bus.wb_write_data = 32'hDEADBEEF;
    tick();
    bus.wb_reg_write = 1'b0;
    bus.rd_addr_a    = 5'd5;
    bus.rd_addr_b    = 5'd0;
    #1;
    n_total++;
    if (bus.rd_data_a !== 32'hDEADBEEF)
      $display("FAIL write_read_a: got %h, want deadbeef", bus.rd_data_a);
    else n_pass++;
    n_total++;
    if (bus.rd_data_b !== 32'h0) $display("FAIL write_read_b: got %h, want 0", bus.rd_data_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_r0();
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd0;
    bus.wb_write_data = 32'h12345678;
    bus.rd_addr_a     = 5'd0;
    bus.rd_addr_b     = 5'd5;
    #1;
    n_total++;
    if (bus.rd_data_a !== 32'h0) $display("FAIL r0_same_cycle: got %h, want 0", bus.rd_data_a);
    else n_pass++;
    n_total++;
    if (bus.rd_data_b !== 32'hDEADBEEF)
      $display("FAIL r0_other_port: got %h, want deadbeef", bus.rd_data_b);
    else n_pass++;
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    n_total++;
    if (bus.rd_data_a !== 32'h0) $display("FAIL r0_after_write: got %h, want 0", bus.rd_data_a);
    else n_pass++;
  endtask

  task automatic test_bypass();
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_addr = 5'd7;
    bus.wb_write_data = 32'h1;
    tick();
    bus.wb_write_data = 32'hA5A5A5A5;
    bus.rd_addr_a     = 5'd7;
    bus.rd_addr_b     = 5'd7;
    #1;
    n_total++;
    if ((bus.rd_data_a !== 32'hA5A5A5A5) || (bus.rd_data_b !== 32'hA5A5A5A5))
      $display("FAIL bypass_on: got a=%h b=%h, want a5a5a5a5", bus.rd_data_a, bus.rd_data_b);
    else n_pass++;
    bus.wb_reg_write = 1'b0;
    #1;
    n_total++;
    if (bus.rd_data_a !== 32'h1) $display("FAIL bypass_off: got %h, want 1", bus.rd_data_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_random_rw();
    logic [31:0] exp_a, exp_b;
    for (int n = 0; n < 300; n++) begin
      bus.rd_addr_a     = 5'($urandom);
      bus.rd_addr_b     = 5'($urandom);
      bus.wb_reg_write  = 1'($urandom_range(0, 1));
      bus.wb_write_addr = ($urandom_range(0, 3) == 0) ? bus.rd_addr_a : 5'($urandom);
      bus.wb_write_data = $urandom;
      #1;
      exp_a = model_read(bus.rd_addr_a);
      exp_b = model_read(bus.rd_addr_b);
      n_total++;
      if ((bus.rd_data_a !== exp_a) || (bus.rd_data_b !== exp_b))
        $display("FAIL random_rw #%0d: got a=%h b=%h, want a=%h b=%h", n, bus.rd_data_a,
                 bus.rd_data_b, exp_a, exp_b);
      else n_pass++;
      tick();
    end
    bus.wb_reg_write = 1'b0;
  endtask

  // One complete dump; each word must equal the register value at the edge it was loaded.
  task automatic dump_session(input string tag, input int ready_pct, input bit do_writes,
                              input bit poke_start, input int stall_word);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    logic [31:0] exp_data;
    logic xfer;
    bus.dump_start   = 1'b1;
    bus.dump_ready   = 1'b0;
    bus.wb_reg_write = 1'b0;
    tick();
    bus.dump_start = 1'b0;
    exp_data = mregs[0];
    while ((k < 32) && (cyc < 4000)) begin
      bus.dump_ready   = (int'($urandom_range(0, 99)) < ready_pct);
      bus.dump_start   = poke_start && (k == 10);
      bus.wb_reg_write = 1'b0;
      if (do_writes) begin
        bus.wb_reg_write  = 1'($urandom_range(0, 1));
        bus.wb_write_addr = 5'($urandom);
        bus.wb_write_data = $urandom;
      end
      if ((k == stall_word) && (stalls < 2)) begin
        bus.dump_ready = 1'b0;
        if (stalls == 0) begin
          bus.wb_reg_write  = 1'b1;
          bus.wb_write_addr = k[4:0];
          bus.wb_write_data = 32'h0000FFFF;
        end
        stalls++;
      end
      #1;
      n_total++;
      if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b110)
        $display("FAIL %s_status word %0d: got v%b b%b d%b, want v1 b1 d0", tag, k,
                 bus.dump_valid, bus.dump_busy, bus.dump_done);
      else n_pass++;
      n_total++;
      if (bus.dump_addr !== k[4:0])
        $display("FAIL %s_addr: got %0d, want %0d", tag, bus.dump_addr, k);
      else n_pass++;
      n_total++;
      if (bus.dump_data !== exp_data)
        $display("FAIL %s_data word %0d: got %h, want %h", tag, k, bus.dump_data, exp_data);
      else n_pass++;
      xfer = bus.dump_ready;
      tick();
      cyc++;
      if (xfer) begin
        k++;
        if (k < 32) exp_data = mregs[k];
      end
    end
    n_total++;
    if (k != 32) $display("FAIL %s_timeout: got %0d words, want 32", tag, k);
    else n_pass++;
    bus.wb_reg_write = 1'b0;
    bus.dump_ready   = 1'b1;
    bus.dump_start   = poke_start;
    #1;
    n_total++;
    if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b011)
      $display("FAIL %s_done: got v%b b%b d%b, want v0 b1 d1", tag, bus.dump_valid,
               bus.dump_busy, bus.dump_done);
    else n_pass++;
    tick();
    bus.dump_start = 1'b0;
    #1;
    n_total++;
    if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b000)
      $display("FAIL %s_idle: got v%b b%b d%b, want all 0", tag, bus.dump_valid,
               bus.dump_busy, bus.dump_done);
    else n_pass++;
  endtask

  task automatic test_dump_full();
    for (int i = 1; i < 32; i++) begin
      bus.wb_reg_write  = 1'b1;
      bus.wb_write_addr = 5'(i);
      bus.wb_write_data = 32'(i * 17);
      tick();
    end
    bus.wb_reg_write = 1'b0;
    dump_session("full", 100, 1'b0, 1'b1, -1);
  endtask

  task automatic test_dump_stall();
    dump_session("stall", 100, 1'b0, 1'b0, 3);
    bus.rd_addr_a = 5'd3;
    #1;
    n_total++;
    if (bus.rd_data_a !== 32'h0000FFFF)
      $display("FAIL stall_readback: got %h, want 0000ffff", bus.rd_data_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_dump_random();
    dump_session("rand", 50, 1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_dump();
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    repeat (10) tick();
    #1;
    n_total++;
    if (bus.dump_addr !== 5'd10) $display("FAIL abort_addr: got %0d, want 10", bus.dump_addr);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_total++;
    if ({bus.dump_valid, bus.dump_busy, bus.dump_done, bus.dump_addr, bus.dump_data} !== '0)
      $display("FAIL abort_outputs: got v%b b%b d%b a%0d %h, want all 0", bus.dump_valid,
               bus.dump_busy, bus.dump_done, bus.dump_addr, bus.dump_data);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      #1;
      n_total++;
      if ((bus.rd_data_a !== 32'h0) || (bus.dump_done !== 1'b0))
        $display("FAIL abort_regs r%0d: got %h done=%b, want 0 done=0", i, bus.rd_data_a,
                 bus.dump_done);
      else n_pass++;
      tick();
    end
    bus.dump_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    tick();
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_random_rw();
    test_dump_full();
    test_dump_stall();
    test_dump_random();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
